calc_op_controller: RTL and testbench

// Sequencer for the 4-function calculator datapath. It latches operands and the

---
 rtl/calc_op_controller.sv | 139 +++++++++++++
 tb/tb_calc_op_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_op_controller.sv
// calc_op_controller
// Sequencer for the 4-function calculator datapath. It latches the operation and
// operands when a start request arrives in IDLE, waits a fixed settle time while the
// external datapath computes, captures the result, and reports done/err. It also
// owns the calculator memory register (store, accumulate, clear, recall as operand A).

module calc_op_controller #(
    parameter int WAIT_CYCLES = 2,
    parameter int OPD_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op_code,
    input  logic [OPD_W-1:0]   a_in,
    input  logic [OPD_W-1:0]   b_in,
    input  logic               use_mem,
    input  logic [1:0]         mem_cmd,
    input  logic [2*OPD_W-1:0] final_result,
    output logic [1:0]         op_select,
    output logic [OPD_W-1:0]   opd_a,
    output logic [OPD_W-1:0]   opd_b,
    output logic [2*OPD_W-1:0] result,
    output logic [2*OPD_W-1:0] mem_value,
    output logic               mem_ovf,
    output logic               busy,
    output logic               done,
    output logic [1:0]         err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] MEM_STORE = 2'b01;
    localparam logic [1:0] MEM_ACC   = 2'b10;
    localparam logic [1:0] MEM_CLEAR = 2'b11;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_MEM  = 2'b10;

    // Last EXEC count value; the capture edge is the one where cnt equals this.
    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    logic [1:0]         state;
    logic [3:0]         cnt;
    logic [2*OPD_W:0]   acc_sum;
    logic               mem_hi_nonzero;
    logic               accept;

    // Memory recall is only legal when the value fits in an operand.
    assign mem_hi_nonzero = |mem_value[2*OPD_W-1:OPD_W];

    // A start is honoured only in IDLE; anything else is dropped, not queued.
    assign accept = (state == IDLE) && start;

    // Accumulate sum carries one extra bit so the carry-out feeds mem_ovf.
    always_comb begin
        acc_sum = {1'b0, mem_value} + {1'b0, result};
    end

    assign busy = (state == EXEC) || (state == DONE);
    assign done = (state == DONE);

    // Operation sequencer: latch operands on start, settle in EXEC, capture, report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            op_select <= 2'b00;
            opd_a     <= '0;
            opd_b     <= '0;
            result    <= '0;
            err       <= ERR_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_select <= op_code;
                        opd_b     <= b_in;
                        opd_a     <= use_mem ? mem_value[OPD_W-1:0] : a_in;
                        cnt       <= 4'd0;
                        if (op_code == OP_DIV && b_in == '0) begin
                            err   <= ERR_DIV0;
                            state <= DONE;
                        end else if (use_mem && mem_hi_nonzero) begin
                            err   <= ERR_MEM;
                            state <= DONE;
                        end else begin
                            err   <= ERR_OK;
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == CNT_LAST) begin
                        result <= final_result;
                        state  <= DONE;
                    end
                    cnt <= cnt + 4'd1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory register: one store/accumulate/clear action per idle cycle without start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_value <= '0;
            mem_ovf   <= 1'b0;
        end else if (state == IDLE && !accept) begin
            case (mem_cmd)
                MEM_STORE: begin
                    mem_value <= result;
                end
                MEM_ACC: begin
                    mem_value <= acc_sum[2*OPD_W-1:0];
                    mem_ovf   <= mem_ovf | acc_sum[2*OPD_W];
                end
                MEM_CLEAR: begin
                    mem_value <= '0;
                    mem_ovf   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_op_controller.sv
// tb_calc_op_controller
// Drives directed operation and memory sequences into calc_op_controller while a
// transaction-level model predicts every output; a compare process checks the DUT
// against that model on every falling edge, and a few literal values pin the model.

module tb_calc_op_controller;

    localparam int WAIT_CYCLES = 2;
    localparam int OPD_W       = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op_code = 2'b00;
    logic [3:0] a_in = 4'd0;
    logic [3:0] b_in = 4'd0;
    logic       use_mem = 1'b0;
    logic [1:0] mem_cmd = 2'b00;
    logic [7:0] final_result;
    logic [1:0] op_select;
    logic [3:0] opd_a;
    logic [3:0] opd_b;
    logic [7:0] result;
    logic [7:0] mem_value;
    logic       mem_ovf;
    logic       busy;
    logic       done;
    logic [1:0] err;

    int checks = 0;
    int errors = 0;
    bit compare_en = 1'b0;

    // Model state: expected register contents plus cycles left until IDLE.
    logic [1:0] m_op = 2'b00;
    logic [3:0] m_a = 4'd0;
    logic [3:0] m_b = 4'd0;
    logic [7:0] m_result = 8'd0;
    logic [7:0] m_mem = 8'd0;
    logic       m_ovf = 1'b0;
    logic [1:0] m_err = 2'b00;
    int         remaining = 0;

    calc_op_controller #(
        .WAIT_CYCLES(WAIT_CYCLES),
        .OPD_W(OPD_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op_code(op_code),
        .a_in(a_in),
        .b_in(b_in),
        .use_mem(use_mem),
        .mem_cmd(mem_cmd),
        .final_result(final_result),
        .op_select(op_select),
        .opd_a(opd_a),
        .opd_b(opd_b),
        .result(result),
        .mem_value(mem_value),
        .mem_ovf(mem_ovf),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    // Arithmetic of the external calculator datapath.
    function automatic logic [7:0] calc(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int r;
        case (op)
            2'b00: r = int'(a) + int'(b);
            2'b01: r = int'(a) - int'(b);
            2'b10: r = int'(a) * int'(b);
            default: r = (b == 4'd0) ? 0 : int'(a) / int'(b);
        endcase
        return 8'(r);
    endfunction

    // Datapath stand-in feeding the controller from its own latched operands.
    always_comb begin
        final_result = calc(op_select, opd_a, opd_b);
    end

    // Transaction model: an accepted start occupies the block for a fixed number of cycles.
    always @(posedge clk or posedge rst) begin
        int sum;
        if (rst) begin
            m_op = 2'b00; m_a = 4'd0; m_b = 4'd0; m_result = 8'd0;
            m_mem = 8'd0; m_ovf = 1'b0; m_err = 2'b00; remaining = 0;
        end else if (remaining > 0) begin
            if (remaining == 2) m_result = calc(m_op, m_a, m_b);
            remaining = remaining - 1;
        end else if (start) begin
            m_op  = op_code;
            m_b   = b_in;
            m_a   = use_mem ? m_mem[3:0] : a_in;
            m_err = 2'b00;
            if (op_code == 2'b11 && b_in == 4'd0) begin
                m_err = 2'b01;
                remaining = 1;
            end else if (use_mem && m_mem > 8'd15) begin
                m_err = 2'b10;
                remaining = 1;
            end else begin
                remaining = WAIT_CYCLES + 1;
            end
        end else begin
            case (mem_cmd)
                2'b01: m_mem = m_result;
                2'b10: begin
                    sum = int'(m_mem) + int'(m_result);
                    m_mem = 8'(sum);
                    if (sum > 255) m_ovf = 1'b1;
                end
                2'b11: begin
                    m_mem = 8'd0;
                    m_ovf = 1'b0;
                end
                default: ;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (compare_en) begin
            checkOutput("op_select", 16'(op_select), 16'(m_op));
            checkOutput("opd_a", 16'(opd_a), 16'(m_a));
            checkOutput("opd_b", 16'(opd_b), 16'(m_b));
            checkOutput("result", 16'(result), 16'(m_result));
            checkOutput("mem_value", 16'(mem_value), 16'(m_mem));
            checkOutput("mem_ovf", 16'(mem_ovf), 16'(m_ovf));
            checkOutput("busy", 16'(busy), 16'(remaining > 0));
            checkOutput("done", 16'(done), 16'(remaining == 1));
            checkOutput("err", 16'(err), 16'(m_err));
        end
    end

    // Presents one start request (or memory command) for exactly one edge.
    task automatic applyStimulus(input logic s, input logic [1:0] op, input logic [3:0] a,
                                 input logic [3:0] b, input logic um, input logic [1:0] mc);
        @(negedge clk);
        start = s; op_code = op; a_in = a; b_in = b; use_mem = um; mem_cmd = mc;
        @(negedge clk);
        start = 1'b0; mem_cmd = 2'b00; use_mem = 1'b0;
    endtask

    // Waits (bounded) for done, reporting falling edges elapsed since the start edge.
    task automatic waitDone(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        if (done !== 1'b1) checkOutput("done_timeout", 16'(done), 16'd1);
    endtask

    task automatic runOp(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic um, output int cycles);
        applyStimulus(1'b1, op, a, b, um, 2'b00);
        waitDone(cycles);
    endtask

    initial begin
        int cyc;
        repeat (2) @(negedge clk);
        compare_en = 1'b1;
        checkOutput("reset_result", 16'(result), 16'd0);
        checkOutput("reset_busy", 16'(busy), 16'd0);
        rst = 1'b0;

        // Reset during EXEC aborts without a done pulse.
        applyStimulus(1'b1, 2'b10, 4'd3, 4'd4, 1'b0, 2'b00);
        checkOutput("abort_busy_before", 16'(busy), 16'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_done", 16'(done), 16'd0);
        checkOutput("abort_result", 16'(result), 16'd0);
        checkOutput("abort_busy", 16'(busy), 16'd0);
        rst = 1'b0;

        // Multiply 15*15 with a two-cycle settle.
        runOp(2'b10, 4'd15, 4'd15, 1'b0, cyc);
        checkOutput("mul_latency", 16'(cyc), 16'd2);
        checkOutput("mul_result", 16'(result), 16'h00E1);
        @(negedge clk);
        checkOutput("mul_done_pulse", 16'(done), 16'd0);

        // Divide by zero skips EXEC and leaves result alone.
        runOp(2'b11, 4'd9, 4'd0, 1'b0, cyc);
        checkOutput("div0_latency", 16'(cyc), 16'd0);
        checkOutput("div0_err", 16'(err), 16'd1);
        checkOutput("div0_result", 16'(result), 16'h00E1);
        @(negedge clk);

        // Memory: store, accumulate with carry, clear.
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 2'b01);
        checkOutput("mem_store", 16'(mem_value), 16'h00E1);
        runOp(2'b10, 4'd8, 4'd4, 1'b0, cyc);
        @(negedge clk);
        checkOutput("err_cleared", 16'(err), 16'd0);
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 2'b10);
        checkOutput("mem_acc", 16'(mem_value), 16'h0001);
        checkOutput("mem_ovf_set", 16'(mem_ovf), 16'd1);
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 2'b11);
        checkOutput("mem_clear", 16'(mem_value), 16'd0);
        checkOutput("mem_ovf_clear", 16'(mem_ovf), 16'd0);

        // Memory as operand A: 7+3, then an out-of-range recall.
        runOp(2'b00, 4'd3, 4'd4, 1'b0, cyc);
        @(negedge clk);
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 2'b01);
        runOp(2'b00, 4'd0, 4'd3, 1'b1, cyc);
        checkOutput("usemem_opd_a", 16'(opd_a), 16'd7);
        checkOutput("usemem_result", 16'(result), 16'h000A);
        @(negedge clk);
        runOp(2'b00, 4'd15, 4'd8, 1'b0, cyc);
        @(negedge clk);
        applyStimulus(1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 2'b01);
        runOp(2'b00, 4'd0, 4'd1, 1'b1, cyc);
        checkOutput("usemem_range_err", 16'(err), 16'd2);
        checkOutput("usemem_range_latency", 16'(cyc), 16'd0);
        @(negedge clk);

        // Start while busy is ignored.
        applyStimulus(1'b1, 2'b10, 4'd2, 4'd3, 1'b0, 2'b00);
        applyStimulus(1'b1, 2'b00, 4'd1, 4'd1, 1'b0, 2'b00);
        waitDone(cyc);
        checkOutput("busy_ignore_result", 16'(result), 16'd6);
        @(negedge clk);
        @(negedge clk);
        checkOutput("busy_ignore_idle", 16'(busy), 16'd0);

        // Start and store together: the operation wins, memory unchanged.
        applyStimulus(1'b1, 2'b00, 4'd1, 4'd2, 1'b0, 2'b01);
        waitDone(cyc);
        checkOutput("collide_result", 16'(result), 16'd3);
        checkOutput("collide_mem", 16'(mem_value), 16'h0017);
        @(negedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
